imem_port_arbiter: RTL and testbench
====================================

# imem_port_arbiter

Shares the single-port, synchronous-read instruction memory between the core's fetch port and a loader/debug port. After reset it holds the core in boot, giving the loader exclusive access to write the program image. Once released, it arbitrates word-wide accesses with fetch priority and a starvation bound for the loader. It sits between the fetch stage, the boot loader and the instruction SRAM.

## Interface
Parameters:
- DEPTH, 64, memory depth in 32-bit words (power of two)
- AW, $clog2(DEPTH), word-index width
- MAX_WAIT, 4, max consecutive cycles a pending loader request may lose to fetch in RUN

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- fetch_req  in  1  fetch read request
- fetch_addr  in  32  byte address
- fetch_gnt  out  1  request accepted this cycle
- fetch_rvalid  out  1  read data/err valid
- fetch_rdata  out  32  instruction word
- fetch_err  out  1  misaligned or out-of-range access, qualifies fetch_rvalid
- load_req  in  1  loader request
- load_we  in  1  1 = write, 0 = read
- load_addr  in  32  byte address
- load_wdata  in  32  write data
- load_done  in  1  single-cycle pulse: image complete, release core
- load_gnt  out  1  request accepted this cycle
- load_rvalid  out  1  response valid (reads and writes)
- load_rdata  out  32  read data (0 for writes)
- load_err  out  1  misaligned or out-of-range, qualifies load_rvalid
- core_run  out  1  core released from boot
- mem_en  out  1  SRAM access enable
- mem_we  out  1  SRAM write enable
- mem_addr  out  AW  SRAM word index
- mem_wdata  out  32  SRAM write data
- mem_rdata  in  32  SRAM read data, valid one cycle after mem_en with mem_we = 0

## Operation
- FSM states are BOOT and RUN. Reset enters BOOT.
- BOOT:
  - Only the loader is granted. fetch_gnt stays 0, and fetch_req is ignored (not queued).
  - load_done moves the FSM to RUN on the next edge. This applies even if a loader access is in flight; its response still completes.
- RUN is a terminal state; only reset leaves it. Arbitration per cycle:
  - Loader wins if wait_cnt == MAX_WAIT or fetch_req = 0.
  - Otherwise fetch wins.
- wait_cnt:
  - Increments when load_req = 1 and load_gnt = 0 in RUN.
  - Clears when load_gnt = 1 or load_req = 0.
  - Saturates at MAX_WAIT.
- At most one grant per cycle. Grants are combinational from the request and registered state.
- Address check:
  - The access is legal iff addr[1:0] = 0 and addr[31:2] < DEPTH.
  - mem_addr = addr[AW+1:2].
  - An illegal access is still granted, but mem_en stays 0. The response carries err = 1 and rdata = 0.
- Writes produce a response with rdata = 0 and err set per the address check.
- core_run = 1 exactly when the state is RUN.

## Timing
- Grant: same cycle as the request. mem_* driven combinationally in the grant cycle.
- Response:
  - *_rvalid is asserted exactly one cycle after *_gnt, for one cycle.
  - *_rdata is mem_rdata passed through, or 0 on error/write.
  - A back-to-back grant every cycle gives full throughput.
- Requesters hold req/addr/wdata stable until gnt. The arbiter does not check this.
- Reset values:
  - State BOOT, wait_cnt 0.
  - All *_gnt, *_rvalid, *_err and mem_en/mem_we are 0.
  - *_rdata is 0 and core_run is 0.
  - Reset mid-access drops the pending response; no rvalid follows.
- Simultaneous load_done and load_req in BOOT: the request is granted that cycle under BOOT rules.
- load_done in RUN is ignored.

## Structure
- Package imem_arb_pkg holds:
  - state enum {ST_BOOT, ST_RUN}
  - owner encoding {OWN_NONE, OWN_FETCH, OWN_LOAD} for the response pipeline register
  - ERR_RDATA = 32'h0
- No sub-module in the arbiter. The bench and top instantiate a separate imem_sram (DEPTH x 32, one-cycle synchronous read, write-first not required) with a $readmemh-capable initializer.

## Test plan
- Boot load, then run:
  - Stimulus: loader writes 32'h00000293 to addr 0x4 and 32'h00100313 to 0x8 while fetch_req = 1.
  - Required: fetch_gnt stays 0 and core_run stays 0.
  - Stimulus: load_done.
  - Required: core_run = 1 next cycle; a fetch of 0x4 returns 32'h00000293 one cycle after grant.
- Fetch streaming: fetch 0x0, 0x4, 0x8 on consecutive cycles in RUN -> three grants back-to-back, rvalid on cycles +1/+2/+3 with matching data.
- Starvation bound (MAX_WAIT = 4): fetch_req held 1 and load_req held 1 -> fetch granted 4 cycles, loader granted on the 5th, wait_cnt back to 0.
- Errors:
  - Fetch of 0x6 -> gnt = 1, mem_en = 0, then rvalid with err = 1 and rdata = 0.
  - Load read of 0x100 (DEPTH = 64) -> load_err = 1.
- Reset mid-access: assert rst_n = 0 in the grant cycle -> no rvalid, state BOOT, core_run = 0, all outputs 0.
- Load read in RUN: a load read of 0x8 with fetch idle -> granted immediately, load_rdata = 32'h00100313 next cycle.

Source files
------------

// File: rtl/imem_arb_pkg.sv
// -----------------------------------------------------------------------------
// imem_arb_pkg
//   Shared types and helpers for the instruction-memory port arbiter.
//   - state_t   : boot/run phase of the arbiter
//   - owner_t   : which port the in-flight response belongs to
//   - ERR_RDATA : read data returned on an error or a write response
//   - addr_legal: word-aligned and inside the memory
// -----------------------------------------------------------------------------
package imem_arb_pkg;

  typedef enum logic {
    ST_BOOT,
    ST_RUN
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_FETCH,
    OWN_LOAD
  } owner_t;

  localparam logic [31:0] ERR_RDATA = 32'h0;

  // An access is legal when it is word aligned and its word index falls
  // inside the memory. The word index is widened to 32 bits so the compare
  // against the depth is done at matching widths.
  function automatic logic addr_legal(input logic [31:0] addr,
                                      input int unsigned depth);
    return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < depth);
  endfunction

endpackage

// File: rtl/imem_sram.sv
// -----------------------------------------------------------------------------
// imem_sram
//   Single-port instruction SRAM, DEPTH x 32, one-cycle synchronous read.
//   Ports:
//     clk   - rising-edge clock
//     en    - access enable
//     we    - write enable (qualified by en)
//     addr  - word index
//     wdata - write data
//     rdata - read data, valid the cycle after a read access
//   No reset: contents persist across arbiter resets so a loaded image
//   survives a core reset.
// -----------------------------------------------------------------------------
module imem_sram #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Read-first behaviour: a write returns the old word, which the arbiter
  // discards anyway because write responses carry zero data.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/imem_port_arbiter.sv
// -----------------------------------------------------------------------------
// imem_port_arbiter
//   Shares a single-port synchronous-read instruction SRAM between the core's
//   fetch port and a loader/debug port. After reset only the loader may
//   access memory (BOOT); a load_done pulse releases the core (RUN), after
//   which fetch has priority but a waiting loader is guaranteed a grant after
//   MAX_WAIT consecutive losses.
//
//   Ports:
//     clk, rst_n                  - clock, asynchronous active-low reset
//     fetch_req/addr              - fetch read request (byte address)
//     fetch_gnt                   - fetch accepted this cycle
//     fetch_rvalid/rdata/err      - fetch response, one cycle after grant
//     load_req/we/addr/wdata      - loader request (read or write)
//     load_done                   - pulse: image complete, release core
//     load_gnt                    - loader accepted this cycle
//     load_rvalid/rdata/err       - loader response, one cycle after grant
//     core_run                    - core released from boot
//     mem_en/we/addr/wdata/rdata  - SRAM port
// -----------------------------------------------------------------------------
module imem_port_arbiter
  import imem_arb_pkg::*;
#(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned AW       = $clog2(DEPTH),
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          fetch_req,
  input  logic [31:0]   fetch_addr,
  output logic          fetch_gnt,
  output logic          fetch_rvalid,
  output logic [31:0]   fetch_rdata,
  output logic          fetch_err,

  input  logic          load_req,
  input  logic          load_we,
  input  logic [31:0]   load_addr,
  input  logic [31:0]   load_wdata,
  input  logic          load_done,
  output logic          load_gnt,
  output logic          load_rvalid,
  output logic [31:0]   load_rdata,
  output logic          load_err,

  output logic          core_run,

  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam int unsigned WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  state_t        state;
  logic [WW-1:0] wait_cnt;

  // Response pipeline: who owns next cycle's response, whether it is an
  // error, and whether its data must be forced to zero (error or write).
  owner_t        resp_owner;
  logic          resp_err;
  logic          resp_zero;

  logic          load_win;
  logic          fetch_win;
  logic [31:0]   sel_addr;
  logic          sel_legal;
  logic          any_gnt;

  // Grant decision. Grants are forced low while reset is asserted so every
  // grant and memory strobe reads 0 during reset even though they are
  // combinational from the requests.
  always_comb begin
    load_win  = 1'b0;
    fetch_win = 1'b0;
    if (rst_n) begin
      if (state == ST_BOOT) begin
        load_win = load_req;
      end else begin
        load_win  = load_req && ((wait_cnt == WAIT_MAX) || !fetch_req);
        fetch_win = fetch_req && !load_win;
      end
    end
  end

  assign load_gnt  = load_win;
  assign fetch_gnt = fetch_win;
  assign any_gnt   = load_win || fetch_win;

  // Memory port: driven from whichever request won this cycle. Illegal
  // accesses are still granted but never reach the SRAM.
  assign sel_addr  = load_win ? load_addr : fetch_addr;
  assign sel_legal = addr_legal(sel_addr, DEPTH);
  assign mem_en    = any_gnt && sel_legal;
  assign mem_we    = mem_en && load_win && load_we;
  assign mem_addr  = sel_addr[AW+1:2];
  assign mem_wdata = load_wdata;

  // Boot/run FSM. RUN is terminal; core_run is registered alongside the
  // state so it changes on the same edge as the phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_BOOT;
      core_run <= 1'b0;
    end else begin
      case (state)
        ST_BOOT: begin
          if (load_done) begin
            state    <= ST_RUN;
            core_run <= 1'b1;
          end
        end
        ST_RUN: begin
          state    <= ST_RUN;
          core_run <= 1'b1;
        end
        default: begin
          state    <= ST_BOOT;
          core_run <= 1'b0;
        end
      endcase
    end
  end

  // Loader starvation counter: counts consecutive cycles a pending loader
  // request loses to fetch in RUN, saturating at MAX_WAIT, where the loader
  // is forced to win.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state == ST_RUN && load_req && !load_win) begin
      if (wait_cnt != WAIT_MAX) begin
        wait_cnt <= wait_cnt + WW'(1);
      end
    end else begin
      wait_cnt <= '0;
    end
  end

  // Response pipeline register: one entry, since rvalid follows the grant
  // by exactly one cycle and only one grant is issued per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_owner <= OWN_NONE;
      resp_err   <= 1'b0;
      resp_zero  <= 1'b0;
    end else begin
      if (load_win) begin
        resp_owner <= OWN_LOAD;
      end else if (fetch_win) begin
        resp_owner <= OWN_FETCH;
      end else begin
        resp_owner <= OWN_NONE;
      end
      resp_err  <= any_gnt && !sel_legal;
      resp_zero <= !sel_legal || (load_win && load_we);
    end
  end

  // Response outputs: SRAM data is passed straight through in the response
  // cycle, replaced by ERR_RDATA for errors, writes and idle cycles.
  assign fetch_rvalid = (resp_owner == OWN_FETCH);
  assign fetch_err    = fetch_rvalid && resp_err;
  assign fetch_rdata  = (fetch_rvalid && !resp_zero) ? mem_rdata : ERR_RDATA;

  assign load_rvalid  = (resp_owner == OWN_LOAD);
  assign load_err     = load_rvalid && resp_err;
  assign load_rdata   = (load_rvalid && !resp_zero) ? mem_rdata : ERR_RDATA;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_imem_port_arbiter
//   Scoreboard bench for imem_port_arbiter with an imem_sram attached.
//   A stimulus process drives one request set per cycle, predicts grants
//   from a behavioural model and queues the expected responses; a monitor
//   process pops and compares whenever the DUT raises an rvalid.
// -----------------------------------------------------------------------------
module tb_imem_port_arbiter;

  localparam int unsigned DEPTH    = 64;
  localparam int unsigned AW       = $clog2(DEPTH);
  localparam int unsigned MAX_WAIT = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fetch_req = 1'b0;
  logic [31:0]   fetch_addr = '0;
  logic          fetch_gnt, fetch_rvalid, fetch_err;
  logic [31:0]   fetch_rdata;
  logic          load_req = 1'b0;
  logic          load_we = 1'b0;
  logic [31:0]   load_addr = '0;
  logic [31:0]   load_wdata = '0;
  logic          load_done = 1'b0;
  logic          load_gnt, load_rvalid, load_err;
  logic [31:0]   load_rdata;
  logic          core_run;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  imem_port_arbiter #(.DEPTH(DEPTH), .AW(AW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata), .fetch_err(fetch_err),
    .load_req(load_req), .load_we(load_we), .load_addr(load_addr),
    .load_wdata(load_wdata), .load_done(load_done), .load_gnt(load_gnt),
    .load_rvalid(load_rvalid), .load_rdata(load_rdata), .load_err(load_err),
    .core_run(core_run),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  imem_sram #(.DEPTH(DEPTH), .AW(AW)) sram (
    .clk(clk), .en(mem_en), .we(mem_we), .addr(mem_addr),
    .wdata(mem_wdata), .rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  resp_t       fq[$];
  resp_t       lq[$];

  // Behavioural model: memory image, boot flag and consecutive-loss count.
  logic [31:0] ref_mem [DEPTH];
  bit          ref_boot = 1'b1;
  int          ref_losses = 0;

  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h",
               name, cyc, actual, expected);
    end
  endtask

  function automatic bit ref_legal(input logic [31:0] a);
    return (a % 4 == 0) && ((a / 4) < DEPTH);
  endfunction

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    r = $urandom_range(15);
    if (r == 0) return ($urandom_range(DEPTH - 1) * 4) + $urandom_range(1, 3);
    if (r == 1) return $urandom | 32'h0000_1000;
    return $urandom_range(DEPTH - 1) * 4;
  endfunction

  // One cycle of stimulus: drive inputs just after the rising edge, then at
  // the falling edge compare grants/memory strobes to the model, queue the
  // expected responses and advance the model to the next cycle.
  task automatic apply_stimulus(input bit fr, input logic [31:0] fa,
                                input bit lr, input bit lw,
                                input logic [31:0] la, input logic [31:0] wd,
                                input bit ld, output bit fg, output bit lg);
    resp_t r;
    bit    legal;
    int    idx;
    fetch_req  = fr;
    fetch_addr = fa;
    load_req   = lr;
    load_we    = lw;
    load_addr  = la;
    load_wdata = wd;
    load_done  = ld;
    @(negedge clk);
    if (ref_boot) begin
      lg = lr;
      fg = 1'b0;
    end else begin
      lg = lr && (ref_losses >= MAX_WAIT || !fr);
      fg = fr && !lg;
    end
    check_output("core_run", core_run, !ref_boot);
    check_output("fetch_gnt", fetch_gnt, fg);
    check_output("load_gnt", load_gnt, lg);
    if (lg || fg) begin
      legal   = ref_legal(lg ? la : fa);
      idx     = legal ? int'((lg ? la : fa) / 4) : 0;
      r.due   = cyc + 1;
      r.err   = !legal;
      r.rdata = (legal && !(lg && lw)) ? ref_mem[idx] : 32'h0;
      check_output("mem_en", mem_en, legal);
      check_output("mem_we", mem_we, legal && lg && lw);
      if (legal) check_output("mem_addr", 32'(mem_addr), idx);
      if (lg) begin
        if (legal && lw) ref_mem[idx] = wd;
        lq.push_back(r);
      end else begin
        fq.push_back(r);
      end
    end else begin
      check_output("mem_en_idle", mem_en, 1'b0);
    end
    if (!ref_boot) begin
      if (lr && !lg) ref_losses = (ref_losses < MAX_WAIT) ? ref_losses + 1 : MAX_WAIT;
      else ref_losses = 0;
    end
    if (ref_boot && ld) ref_boot = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_fetch_gnt"}, fetch_gnt, 1'b0);
    check_output({tag, "_load_gnt"}, load_gnt, 1'b0);
    check_output({tag, "_fetch_rvalid"}, fetch_rvalid, 1'b0);
    check_output({tag, "_load_rvalid"}, load_rvalid, 1'b0);
    check_output({tag, "_fetch_err"}, fetch_err, 1'b0);
    check_output({tag, "_load_err"}, load_err, 1'b0);
    check_output({tag, "_fetch_rdata"}, fetch_rdata, 32'h0);
    check_output({tag, "_load_rdata"}, load_rdata, 32'h0);
    check_output({tag, "_mem_en"}, mem_en, 1'b0);
    check_output({tag, "_mem_we"}, mem_we, 1'b0);
    check_output({tag, "_core_run"}, core_run, 1'b0);
  endtask

  // Monitor: every rvalid must match the oldest queued expectation for its
  // port, arriving exactly on its due cycle; an overdue entry is a miss.
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (fetch_rvalid) begin
        if (fq.size() == 0) begin
          check_output("fetch_rvalid_unexpected", 1'b1, 1'b0);
        end else begin
          e = fq.pop_front();
          check_output("fetch_resp_cycle", cyc, e.due);
          check_output("fetch_err", fetch_err, e.err);
          check_output("fetch_rdata", fetch_rdata, e.rdata);
        end
      end else if (fq.size() > 0 && fq[0].due <= cyc) begin
        e = fq.pop_front();
        check_output("fetch_rvalid_missing", 1'b0, 1'b1);
      end
      if (load_rvalid) begin
        if (lq.size() == 0) begin
          check_output("load_rvalid_unexpected", 1'b1, 1'b0);
        end else begin
          e = lq.pop_front();
          check_output("load_resp_cycle", cyc, e.due);
          check_output("load_err", load_err, e.err);
          check_output("load_rdata", load_rdata, e.rdata);
        end
      end else if (lq.size() > 0 && lq[0].due <= cyc) begin
        e = lq.pop_front();
        check_output("load_rvalid_missing", 1'b0, 1'b1);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit          fg, lg, fp, lp, lw;
    logic [31:0] fa, la, wd;

    // Reset with a loader request pending: grants must still read 0.
    load_req = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    load_req = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Boot: loader writes the whole image while fetch keeps requesting.
    for (int i = 0; i < DEPTH; i++) begin
      wd = (i == 1) ? 32'h0000_0293 : (i == 2) ? 32'h0010_0313 : $urandom;
      apply_stimulus(1'b1, 32'h4, 1'b1, 1'b1, 32'(i * 4), wd, 1'b0, fg, lg);
    end

    // load_done together with a loader read: still served under boot rules.
    apply_stimulus(1'b1, 32'h4, 1'b1, 1'b0, 32'h4, 32'h0, 1'b1, fg, lg);

    // First fetch in run, then a back-to-back stream 0x0, 0x4, 0x8.
    apply_stimulus(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, fg, lg);
    for (int i = 0; i < 3; i++)
      apply_stimulus(1'b1, 32'(i * 4), 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, fg, lg);

    // Starvation bound: both ports hold requests continuously.
    for (int i = 0; i < 7; i++)
      apply_stimulus(1'b1, 32'(i * 4), 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, fg, lg);

    // Error cases: misaligned fetch and out-of-range loader read.
    apply_stimulus(1'b1, 32'h6, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, fg, lg);
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, fg, lg);

    // Loader read in run with fetch idle, plus a stray load_done.
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b1, fg, lg);

    // Reset asserted right after a grant: the response must be dropped.
    fetch_req  = 1'b0;
    load_req   = 1'b1;
    load_we    = 1'b0;
    load_addr  = 32'h8;
    load_done  = 1'b0;
    @(negedge clk);
    check_output("midrst_load_gnt", load_gnt, 1'b1);
    #1 rst_n = 1'b0;
    fq.delete();
    lq.delete();
    ref_boot   = 1'b1;
    ref_losses = 0;
    @(negedge clk);
    check_reset_outputs("midrst");
    load_req = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back in boot: fetch is ignored, then release and run randomly.
    for (int i = 0; i < 3; i++)
      apply_stimulus(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, fg, lg);
    apply_stimulus(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, fg, lg);

    fp = 1'b0;
    lp = 1'b0;
    fa = '0;
    la = '0;
    wd = '0;
    lw = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!fp && $urandom_range(9) < 7) begin
        fp = 1'b1;
        fa = rand_addr();
      end
      if (!lp && $urandom_range(9) < 5) begin
        lp = 1'b1;
        la = rand_addr();
        lw = 1'($urandom_range(1));
        wd = $urandom;
      end
      apply_stimulus(fp, fa, lp, lw, la, wd, ($urandom_range(19) == 0), fg, lg);
      if (fg) fp = 1'b0;
      if (lg) lp = 1'b0;
    end

    // Drain and confirm every expected response was seen.
    for (int i = 0; i < 3; i++)
      apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, fg, lg);
    check_output("fetch_queue_drained", fq.size(), 0);
    check_output("load_queue_drained", lq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
